// File: rtl/data_memory_arbiter_pkg.sv
// rtl/data_memory_arbiter_pkg.sv - shared constants, state and tag types for the data memory arbiter
package data_memory_arbiter_pkg;

   localparam logic [1:0] REGION_RAM      = 2'b00;
   localparam logic [1:0] REGION_IO_READ  = 2'b01;
   localparam logic [1:0] REGION_IO_WRITE = 2'b10;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_AUX = 1'b1;

   typedef enum logic {
      IDLE,
      IO_HOLD
   } state_t;

   // One outstanding read: which port it belongs to and whether it is live.
   typedef struct packed {
      logic valid;
      logic port;
   } tag_t;

   // Only the IO-read region needs the address held for a second cycle;
   // every other region returns read data with RAM timing.
   function automatic logic needs_io_hold(input logic [1:0] region);
      logic hold;
      case (region)
         REGION_IO_READ:              hold = 1'b1;
         REGION_RAM, REGION_IO_WRITE: hold = 1'b0;
         default:                     hold = 1'b0;
      endcase
      return hold;
   endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// rtl/data_memory_arbiter_if.sv - requester and data_memory signal bundle for the arbiter
interface data_memory_arbiter_if;

   logic        p0_req;
   logic        p0_we;
   logic [31:0] p0_address;
   logic [3:0]  p0_byteena;
   logic [31:0] p0_data;
   logic        p0_ack;
   logic        p0_rvalid;
   logic [31:0] p0_rdata;

   logic        p1_req;
   logic        p1_we;
   logic [31:0] p1_address;
   logic [3:0]  p1_byteena;
   logic [31:0] p1_data;
   logic        p1_ack;
   logic        p1_rvalid;
   logic [31:0] p1_rdata;

   logic [31:0] mem_address;
   logic [3:0]  mem_byteena;
   logic [31:0] mem_data;
   logic        mem_wren;
   logic [31:0] mem_q;

   logic        busy;

   // Arbiter side.
   modport slave (
      input  p0_req, p0_we, p0_address, p0_byteena, p0_data,
      output p0_ack, p0_rvalid, p0_rdata,
      input  p1_req, p1_we, p1_address, p1_byteena, p1_data,
      output p1_ack, p1_rvalid, p1_rdata,
      output mem_address, mem_byteena, mem_data, mem_wren,
      input  mem_q,
      output busy
   );

   // Requesters plus the data_memory itself.
   modport master (
      output p0_req, p0_we, p0_address, p0_byteena, p0_data,
      input  p0_ack, p0_rvalid, p0_rdata,
      output p1_req, p1_we, p1_address, p1_byteena, p1_data,
      input  p1_ack, p1_rvalid, p1_rdata,
      input  mem_address, mem_byteena, mem_data, mem_wren,
      output mem_q,
      input  busy
   );

endinterface

// File: rtl/data_memory_arbiter_grant_select.sv
// rtl/data_memory_arbiter_grant_select.sv - grant choice; DATA_MEMORY_ARBITER_ROUND_ROBIN_EN selects round-robin
module arbiter_grant_select
   import data_memory_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic p0_req,
   input  logic p1_req,
   output logic grant_valid,
   output logic grant_port
);

   assign grant_valid = enable & (p0_req | p1_req);

`ifdef DATA_MEMORY_ARBITER_ROUND_ROBIN_EN

   logic last_q, last_d;

   // On a conflict the port that did not win last time gets the grant.
   always_comb begin
      grant_port = PORT_CPU;
      if (p1_req && (!p0_req || last_q == PORT_CPU)) grant_port = PORT_AUX;
      last_d = last_q;
      if (grant_valid) last_d = grant_port;
   end

   // Last-winner flop; starts at port 1 so port 0 takes the first conflict.
   always_ff @(posedge clock) begin
      if (reset) last_q <= PORT_AUX;
      else       last_q <= last_d;
   end

`else

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] count_q, count_d;
   logic          starved;

   assign starved = (count_q == CW'(STARVE_LIMIT));

   // Port 0 has priority until port 1 has waited through STARVE_LIMIT port-0 grants.
   always_comb begin
      grant_port = PORT_CPU;
      if (p1_req && (!p0_req || starved)) grant_port = PORT_AUX;
      count_d = count_q;
      if (!p1_req) begin
         count_d = '0;
      end else if (grant_valid) begin
         if (grant_port == PORT_AUX) count_d = '0;
         else if (!starved)          count_d = count_q + 1'b1;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clock) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

`endif

endmodule

// File: rtl/data_memory_arbiter_reg.sv
// rtl/data_memory_arbiter_reg.sv - plain register with synchronous active-high clear
module data_memory_arbiter_reg #(
   parameter int WIDTH = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Capture d every cycle; reset clears to zero.
   always_ff @(posedge clock) begin
      if (reset) q <= '0;
      else       q <= d;
   end

endmodule

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - shares data_memory between the CPU port and the DMA/debug port
module data_memory_arbiter
   import data_memory_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input logic                 clock,
   input logic                 reset,
   data_memory_arbiter_if.slave bus
);

   state_t      state_q, state_d;
   logic [31:0] address_q, address_d;
   logic [31:0] data_q, data_d;
   logic [3:0]  byteena_q, byteena_d;
   tag_t        hold_tag_q, hold_tag_d;
   tag_t        ret_tag_q, ret_tag_d;

   logic        grant_enable, grant_valid, grant_port;
   logic        sel_we;
   logic [31:0] sel_address, sel_data;
   logic [3:0]  sel_byteena;
   logic        wren, ack0, ack1, ret0, ret1;

   assign grant_enable = !reset && (state_q == IDLE);

   arbiter_grant_select #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_grant (
      .clock       (clock),
      .reset       (reset),
      .enable      (grant_enable),
      .p0_req      (bus.p0_req),
      .p1_req      (bus.p1_req),
      .grant_valid (grant_valid),
      .grant_port  (grant_port)
   );

   // Steer the selected port's request fields toward the memory.
   always_comb begin
      sel_we      = bus.p0_we;
      sel_address = bus.p0_address;
      sel_byteena = bus.p0_byteena;
      sel_data    = bus.p0_data;
      if (grant_port == PORT_AUX) begin
         sel_we      = bus.p1_we;
         sel_address = bus.p1_address;
         sel_byteena = bus.p1_byteena;
         sel_data    = bus.p1_data;
      end
   end

   // Issue the grant, hold the bus through IO reads and tag outgoing reads.
   // An IO read parks its tag in hold_tag for one cycle before it reaches ret_tag.
   always_comb begin
      state_d    = state_q;
      address_d  = address_q;
      byteena_d  = byteena_q;
      data_d     = data_q;
      hold_tag_d = '0;
      ret_tag_d  = hold_tag_q;
      wren       = 1'b0;
      ack0       = 1'b0;
      ack1       = 1'b0;
      if (reset) begin
         state_d   = IDLE;
         address_d = '0;
         byteena_d = '0;
         data_d    = '0;
         ret_tag_d = '0;
      end else if (state_q == IO_HOLD) begin
         state_d = IDLE;
      end else if (grant_valid) begin
         address_d = sel_address;
         byteena_d = sel_byteena;
         data_d    = sel_data;
         wren      = sel_we;
         ack0      = (grant_port == PORT_CPU);
         ack1      = (grant_port == PORT_AUX);
         if (!sel_we) begin
            if (needs_io_hold(sel_address[11:10])) begin
               state_d    = IO_HOLD;
               hold_tag_d = '{valid: 1'b1, port: grant_port};
            end else begin
               ret_tag_d  = '{valid: 1'b1, port: grant_port};
            end
         end
      end
   end

   // State and last-driven memory fields.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         address_q <= '0;
         byteena_q <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         address_q <= address_d;
         byteena_q <= byteena_d;
         data_q    <= data_d;
      end
   end

   data_memory_arbiter_reg #(.WIDTH($bits(tag_t))) u_hold_tag (
      .clock (clock),
      .reset (reset),
      .d     (hold_tag_d),
      .q     (hold_tag_q)
   );

   data_memory_arbiter_reg #(.WIDTH($bits(tag_t))) u_ret_tag (
      .clock (clock),
      .reset (reset),
      .d     (ret_tag_d),
      .q     (ret_tag_q)
   );

   assign ret0 = !reset && ret_tag_q.valid && (ret_tag_q.port == PORT_CPU);
   assign ret1 = !reset && ret_tag_q.valid && (ret_tag_q.port == PORT_AUX);

   assign bus.p0_ack      = ack0;
   assign bus.p1_ack      = ack1;
   assign bus.p0_rvalid   = ret0;
   assign bus.p1_rvalid   = ret1;
   assign bus.p0_rdata    = ret0 ? bus.mem_q : 32'h0;
   assign bus.p1_rdata    = ret1 ? bus.mem_q : 32'h0;
   assign bus.mem_address = address_d;
   assign bus.mem_byteena = byteena_d;
   assign bus.mem_data    = data_d;
   assign bus.mem_wren    = wren;
   assign bus.busy        = !reset && ((state_q == IO_HOLD) || ret_tag_q.valid);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - directed vector bench for data_memory_arbiter with a data_memory model
module tb_data_memory_arbiter;

   localparam int LIMIT = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   data_memory_arbiter_if bus ();

   data_memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // data_memory model: registered read, IO-read region returns the IO input bus.
   logic [31:0] mem [0:1023];
   logic [9:0]  io_in = 10'h2A5;

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (a[11:10] == 2'b01) return {22'b0, io_in};
      return mem[a[11:2]];
   endfunction

   always @(posedge clock) begin
      if (bus.mem_wren)
         for (int b = 0; b < 4; b++)
            if (bus.mem_byteena[b]) mem[bus.mem_address[11:2]][8*b +: 8] <= bus.mem_data[8*b +: 8];
      bus.mem_q <= model_read(bus.mem_address);
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
      bus.p0_req = r0; bus.p0_we = w0; bus.p0_address = a0; bus.p0_data = d0; bus.p0_byteena = 4'hF;
      bus.p1_req = r1; bus.p1_we = w1; bus.p1_address = a1; bus.p1_data = d1; bus.p1_byteena = 4'hF;
   endtask

   typedef struct {
      logic r0; logic w0; logic [31:0] a0; logic [31:0] d0;
      logic r1; logic w1; logic [31:0] a1; logic [31:0] d1;
      logic ack0; logic ack1;
      logic rv0; logic [31:0] rd0;
      logic rv1; logic [31:0] rd1;
      logic [31:0] maddr; logic wren; logic busy;
   } vec_t;

   vec_t vecs [22];

   // Reference grant model for two continuously requesting ports.
   int          m_cnt;
   logic        m_last;
   logic        prev_g, prev_w;
   logic [31:0] m_addr;

   task automatic arb_cycle(input logic r0, input logic r1, input string tag);
      logic w, g;
      logic [31:0] ea;
      drive(r0, 1'b0, 32'h4, 32'h0, r1, 1'b0, 32'h8, 32'h0);
      g = r0 | r1;
`ifdef DATA_MEMORY_ARBITER_ROUND_ROBIN_EN
      w = (r0 && r1) ? ~m_last : r1;
`else
      w = (r0 && r1) ? (m_cnt == LIMIT) : r1;
`endif
      ea = g ? (w ? 32'h8 : 32'h4) : m_addr;
      @(negedge clock);
      chk({tag, " ack0"}, bus.p0_ack, g && !w);
      chk({tag, " ack1"}, bus.p1_ack, g && w);
      chk({tag, " rv0"}, bus.p0_rvalid, prev_g && !prev_w);
      chk({tag, " rv1"}, bus.p1_rvalid, prev_g && prev_w);
      chk({tag, " rd0"}, bus.p0_rdata, (prev_g && !prev_w) ? 32'hA0A00004 : 32'h0);
      chk({tag, " rd1"}, bus.p1_rdata, (prev_g && prev_w) ? 32'hB0B00008 : 32'h0);
      chk({tag, " maddr"}, bus.mem_address, ea);
      if (g) m_last = w;
      if (!r1) m_cnt = 0;
      else if (g && w) m_cnt = 0;
      else if (g && m_cnt < LIMIT) m_cnt++;
      prev_g = g; prev_w = w; m_addr = ea;
      @(posedge clock); #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not reach summary");
      $fatal(1);
   end

   initial begin
      //              r0   w0   a0          d0            r1   w1   a1          d1            ack0 ack1 rv0  rd0           rv1  rd1           maddr       wren busy
      vecs[0]  = '{1'b0,1'b0,32'h000,32'h0,        1'b0,1'b0,32'h000,32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h000,1'b0,1'b0};
      vecs[1]  = '{1'b1,1'b1,32'h004,32'hA0A00004, 1'b0,1'b0,32'h000,32'h0,        1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h004,1'b1,1'b0};
      vecs[2]  = '{1'b0,1'b0,32'h000,32'h0,        1'b1,1'b1,32'h008,32'hB0B00008, 1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        32'h008,1'b1,1'b0};
      vecs[3]  = '{1'b1,1'b0,32'h004,32'h0,        1'b0,1'b0,32'h000,32'h0,        1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h004,1'b0,1'b0};
      vecs[4]  = '{1'b0,1'b0,32'h000,32'h0,        1'b1,1'b0,32'h008,32'h0,        1'b0,1'b1,1'b1,32'hA0A00004, 1'b0,32'h0,        32'h008,1'b0,1'b1};
      vecs[5]  = '{1'b0,1'b0,32'h000,32'h0,        1'b0,1'b0,32'h000,32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b1,32'hB0B00008, 32'h008,1'b0,1'b1};
      vecs[6]  = '{1'b0,1'b0,32'h000,32'h0,        1'b0,1'b0,32'h000,32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h008,1'b0,1'b0};
      vecs[7]  = '{1'b1,1'b0,32'h400,32'h0,        1'b0,1'b0,32'h000,32'h0,        1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h400,1'b0,1'b0};
      vecs[8]  = '{1'b0,1'b0,32'h000,32'h0,        1'b1,1'b1,32'h801,32'h00123456, 1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h400,1'b0,1'b1};
      vecs[9]  = '{1'b0,1'b0,32'h000,32'h0,        1'b1,1'b1,32'h801,32'h00123456, 1'b0,1'b1,1'b1,32'h000002A5, 1'b0,32'h0,        32'h801,1'b1,1'b1};
      vecs[10] = '{1'b1,1'b0,32'h801,32'h0,        1'b0,1'b0,32'h000,32'h0,        1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h801,1'b0,1'b0};
      vecs[11] = '{1'b0,1'b0,32'h000,32'h0,        1'b0,1'b0,32'h000,32'h0,        1'b0,1'b0,1'b1,32'h00123456, 1'b0,32'h0,        32'h801,1'b0,1'b1};
      vecs[12] = '{1'b1,1'b1,32'h010,32'hDEADBEEF, 1'b0,1'b0,32'h000,32'h0,        1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h010,1'b1,1'b0};
      vecs[13] = '{1'b1,1'b0,32'h010,32'h0,        1'b0,1'b0,32'h000,32'h0,        1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h010,1'b0,1'b0};
      vecs[14] = '{1'b0,1'b0,32'h000,32'h0,        1'b0,1'b0,32'h000,32'h0,        1'b0,1'b0,1'b1,32'hDEADBEEF, 1'b0,32'h0,        32'h010,1'b0,1'b1};
      vecs[15] = '{1'b0,1'b0,32'h000,32'h0,        1'b1,1'b0,32'h404,32'h0,        1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        32'h404,1'b0,1'b0};
      vecs[16] = '{1'b0,1'b0,32'h000,32'h0,        1'b0,1'b0,32'h000,32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h404,1'b0,1'b1};
      vecs[17] = '{1'b0,1'b0,32'h000,32'h0,        1'b0,1'b0,32'h000,32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b1,32'h000002A5, 32'h404,1'b0,1'b1};
      vecs[18] = '{1'b0,1'b0,32'h000,32'h0,        1'b0,1'b0,32'h000,32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h404,1'b0,1'b0};
      vecs[19] = '{1'b0,1'b0,32'h000,32'h0,        1'b1,1'b1,32'hC04,32'hCAFEF00D, 1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        32'hC04,1'b1,1'b0};
      vecs[20] = '{1'b0,1'b0,32'h000,32'h0,        1'b1,1'b0,32'hC04,32'h0,        1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        32'hC04,1'b0,1'b0};
      vecs[21] = '{1'b0,1'b0,32'h000,32'h0,        1'b0,1'b0,32'h000,32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b1,32'hCAFEF00D, 32'hC04,1'b0,1'b1};

      // Reset state.
      drive(1'b1, 1'b1, 32'h123, 32'h55, 1'b1, 1'b1, 32'h456, 32'h66);
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst ack0", bus.p0_ack, 1'b0);
      chk("rst ack1", bus.p1_ack, 1'b0);
      chk("rst rv0", bus.p0_rvalid, 1'b0);
      chk("rst rv1", bus.p1_rvalid, 1'b0);
      chk("rst rd0", bus.p0_rdata, 32'h0);
      chk("rst rd1", bus.p1_rdata, 32'h0);
      chk("rst wren", bus.mem_wren, 1'b0);
      chk("rst maddr", bus.mem_address, 32'h0);
      chk("rst mbe", bus.mem_byteena, 4'h0);
      chk("rst mdata", bus.mem_data, 32'h0);
      chk("rst busy", bus.busy, 1'b0);
      @(posedge clock); #1;
      reset = 1'b0;

      // Table of single-cycle vectors.
      for (int i = 0; i < 22; i++) begin
         drive(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0, vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
         @(negedge clock);
         chk($sformatf("v%0d ack0", i), bus.p0_ack, vecs[i].ack0);
         chk($sformatf("v%0d ack1", i), bus.p1_ack, vecs[i].ack1);
         chk($sformatf("v%0d rv0", i), bus.p0_rvalid, vecs[i].rv0);
         chk($sformatf("v%0d rd0", i), bus.p0_rdata, vecs[i].rd0);
         chk($sformatf("v%0d rv1", i), bus.p1_rvalid, vecs[i].rv1);
         chk($sformatf("v%0d rd1", i), bus.p1_rdata, vecs[i].rd1);
         chk($sformatf("v%0d maddr", i), bus.mem_address, vecs[i].maddr);
         chk($sformatf("v%0d wren", i), bus.mem_wren, vecs[i].wren);
         chk($sformatf("v%0d busy", i), bus.busy, vecs[i].busy);
         @(posedge clock); #1;
      end

      // Both ports reading continuously, then a port-1 gap that clears the counter.
      m_cnt = 0; m_last = 1'b1; prev_g = 1'b0; prev_w = 1'b0; m_addr = 32'hC04;
      for (int i = 0; i < 12; i++) arb_cycle(1'b1, 1'b1, $sformatf("arb%0d", i));
      arb_cycle(1'b0, 1'b0, "arb_idle");
      for (int i = 0; i < 3; i++) arb_cycle(1'b1, 1'b1, $sformatf("gap_a%0d", i));
      arb_cycle(1'b1, 1'b0, "gap_p0");
      for (int i = 0; i < 6; i++) arb_cycle(1'b1, 1'b1, $sformatf("gap_b%0d", i));
      arb_cycle(1'b0, 1'b0, "gap_end");

      // Request withdrawn during IO_HOLD is never issued.
      drive(1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clock);
      chk("wd ack0", bus.p0_ack, 1'b1);
      @(posedge clock); #1;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h020, 32'hDEADDEAD);
      @(negedge clock);
      chk("wd hold ack1", bus.p1_ack, 1'b0);
      chk("wd hold wren", bus.mem_wren, 1'b0);
      chk("wd hold maddr", bus.mem_address, 32'h400);
      chk("wd hold busy", bus.busy, 1'b1);
      @(posedge clock); #1;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clock);
      chk("wd ack1", bus.p1_ack, 1'b0);
      chk("wd wren", bus.mem_wren, 1'b0);
      chk("wd maddr", bus.mem_address, 32'h400);
      chk("wd rv0", bus.p0_rvalid, 1'b1);
      chk("wd rd0", bus.p0_rdata, 32'h000002A5);
      @(posedge clock); #1;

      // Reset while in IO_HOLD drops the pending return.
      drive(1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clock);
      chk("rh ack0", bus.p0_ack, 1'b1);
      @(posedge clock); #1;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);
      reset = 1'b1;
      @(negedge clock);
      chk("rh ack1", bus.p1_ack, 1'b0);
      chk("rh rv0", bus.p0_rvalid, 1'b0);
      chk("rh wren", bus.mem_wren, 1'b0);
      chk("rh busy", bus.busy, 1'b0);
      chk("rh maddr", bus.mem_address, 32'h0);
      @(posedge clock); #1;
      reset = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk($sformatf("post%0d rv0", i), bus.p0_rvalid, 1'b0);
         chk($sformatf("post%0d rv1", i), bus.p1_rvalid, 1'b0);
         chk($sformatf("post%0d busy", i), bus.busy, 1'b0);
         chk($sformatf("post%0d wren", i), bus.mem_wren, 1'b0);
         chk($sformatf("post%0d maddr", i), bus.mem_address, 32'h0);
         @(posedge clock); #1;
      end

      // Counter / last-winner restart from reset values.
      m_cnt = 0; m_last = 1'b1; prev_g = 1'b0; prev_w = 1'b0; m_addr = 32'h0;
      for (int i = 0; i < 6; i++) arb_cycle(1'b1, 1'b1, $sformatf("prst%0d", i));
      arb_cycle(1'b0, 1'b0, "prst_end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
